// File: rtl/can_crc_pkg.sv
// Shared constants and state type for the CAN CRC engine.
package can_crc_pkg;

    localparam int unsigned            CAN_CRC_W    = 15;
    localparam logic [CAN_CRC_W-1:0]   CAN_CRC_POLY = 15'h4599;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StShift,
        StCheck
    } crc_state_t;

endpackage

// File: rtl/crc_lfsr_step.sv
// One serial LFSR step of an MSB-first CRC: shift left, fold in POLY when feedback is set.
module crc_lfsr_step #(
    parameter int unsigned       CRC_W = 15,
    parameter logic [CRC_W-1:0]  POLY  = 15'h4599
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             din,
    output logic [CRC_W-1:0] crc_next
);

    logic w_fb;

    assign w_fb     = crc[CRC_W-1] ^ din;
    assign crc_next = {crc[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);

endmodule

// File: rtl/can_crc_engine.sv
// Serial CRC generator/checker: accumulates data bits, then serialises (tx) or
// checks (rx) the CRC field.
module can_crc_engine
    import can_crc_pkg::*;
#(
    parameter int unsigned       CRC_W = CAN_CRC_W,
    parameter logic [CRC_W-1:0]  POLY  = CAN_CRC_POLY,
    parameter logic [CRC_W-1:0]  INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             din,
    input  logic             din_vld,
    input  logic             data_last,
    output logic [CRC_W-1:0] crc,
    output logic             tx_bit,
    output logic             tx_bit_vld,
    output logic             tx_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(CRC_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CRC_W - 1);

    crc_state_t       r_state, w_state_d;
    logic [CRC_W-1:0] r_crc, w_crc_d, w_step;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_mode, w_mode_d;
    logic             r_tx_done, w_tx_done_d;
    logic             r_crc_ok, w_crc_ok_d;
    logic             r_crc_err, w_crc_err_d;
    logic             w_last_strobe;

    crc_lfsr_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_step (
        .crc      (r_crc),
        .din      (din),
        .crc_next (w_step)
    );

    assign w_last_strobe = din_vld && (r_cnt == LAST_CNT);

    always_comb begin
        w_state_d   = r_state;
        w_crc_d     = r_crc;
        w_cnt_d     = r_cnt;
        w_mode_d    = r_mode;
        w_tx_done_d = 1'b0;
        w_crc_ok_d  = 1'b0;
        w_crc_err_d = 1'b0;
        if (start) begin
            // Restart wins over abort and discards any same-cycle data bit.
            w_state_d = StAccum;
            w_crc_d   = INIT;
            w_cnt_d   = '0;
            w_mode_d  = mode;
        end else if (abort) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: w_state_d = StIdle;
                StAccum: begin
                    if (din_vld) begin
                        w_crc_d = w_step;
                        if (data_last) begin
                            w_state_d = r_mode ? StCheck : StShift;
                            w_cnt_d   = '0;
                        end
                    end
                end
                StShift: begin
                    if (din_vld) begin
                        w_crc_d = {r_crc[CRC_W-2:0], 1'b0};
                        w_cnt_d = r_cnt + CNT_W'(1);
                        if (w_last_strobe) begin
                            w_state_d   = StIdle;
                            w_tx_done_d = 1'b1;
                        end
                    end
                end
                StCheck: begin
                    if (din_vld) begin
                        w_crc_d = w_step;
                        w_cnt_d = r_cnt + CNT_W'(1);
                        if (w_last_strobe) begin
                            // Residue over data plus received CRC is zero for an intact frame.
                            w_state_d   = StIdle;
                            w_crc_ok_d  = (w_step == '0);
                            w_crc_err_d = (w_step != '0);
                        end
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_crc     <= '0;
            r_cnt     <= '0;
            r_mode    <= 1'b0;
            r_tx_done <= 1'b0;
            r_crc_ok  <= 1'b0;
            r_crc_err <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_crc     <= w_crc_d;
            r_cnt     <= w_cnt_d;
            r_mode    <= w_mode_d;
            r_tx_done <= w_tx_done_d;
            r_crc_ok  <= w_crc_ok_d;
            r_crc_err <= w_crc_err_d;
        end
    end

    assign crc        = r_crc;
    assign tx_bit_vld = (r_state == StShift);
    assign tx_bit     = (r_state == StShift) & r_crc[CRC_W-1];
    assign tx_done    = r_tx_done;
    assign crc_ok     = r_crc_ok;
    assign crc_err    = r_crc_err;
    assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_can_crc_engine.sv
// Self-checking bench for can_crc_engine against a polynomial long-division model.
module tb_can_crc_engine;

    localparam int unsigned P15 = 32'h4599;
    localparam int unsigned P8  = 32'h07;

    logic        clk = 1'b0;
    logic        rst_n, start, mode, abort, din, din_vld, data_last;
    logic [14:0] crc;
    logic        tx_bit, tx_bit_vld, tx_done, crc_ok, crc_err, busy;
    logic [7:0]  crc8;
    logic        tx_bit8, tx_bit_vld8, tx_done8, crc_ok8, crc_err8, busy8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    can_crc_engine dut (
        .clk (clk), .rst_n (rst_n), .start (start), .mode (mode), .abort (abort),
        .din (din), .din_vld (din_vld), .data_last (data_last), .crc (crc),
        .tx_bit (tx_bit), .tx_bit_vld (tx_bit_vld), .tx_done (tx_done),
        .crc_ok (crc_ok), .crc_err (crc_err), .busy (busy)
    );

    can_crc_engine #(.CRC_W (8), .POLY (8'h07), .INIT (8'h00)) dut8 (
        .clk (clk), .rst_n (rst_n), .start (start), .mode (mode), .abort (abort),
        .din (din), .din_vld (din_vld), .data_last (data_last), .crc (crc8),
        .tx_bit (tx_bit8), .tx_bit_vld (tx_bit_vld8), .tx_done (tx_done8),
        .crc_ok (crc_ok8), .crc_err (crc_err8), .busy (busy8)
    );

    // Remainder of msg(x) * x^w divided by x^w + poly, via modulo-2 long division.
    function automatic int unsigned poly_rem(input bit msg[$], input int w, input int unsigned poly);
        bit          d[$];
        int unsigned r;
        d = msg;
        for (int k = 0; k < w; k++) d.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++) begin
            if (d[i]) begin
                for (int j = 0; j < w; j++) d[i + 1 + j] = d[i + 1 + j] ^ poly[w - 1 - j];
            end
        end
        r = 0;
        for (int j = 0; j < w; j++) r = (r << 1) | 32'(d[msg.size() + j]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit b, input bit last);
        din = b; din_vld = 1'b1; data_last = last;
        step();
        din_vld = 1'b0; data_last = 1'b0;
    endtask

    task automatic pulse_start(input bit m);
        start = 1'b1; mode = m;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            din = 1'($urandom); data_last = 1'($urandom);
            step();
        end
        data_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({tx_bit, tx_bit_vld, tx_done, crc_ok, crc_err, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outs: got %b required 000000",
                     {tx_bit, tx_bit_vld, tx_done, crc_ok, crc_err, busy});
        end
        checks++;
        if (crc !== 15'h0 || crc8 !== 8'h0) begin
            failures++;
            $display("FAIL reset_crc: got %h/%h required 0/0", crc, crc8);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || crc !== 15'h0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b crc=%h required busy=0 crc=0", busy, crc);
        end
    endtask

    task automatic test_tx_single();
        logic [14:0] seq = 15'b100010110011001;
        pulse_start(1'b0);
        checks++;
        if (busy !== 1'b1 || crc !== 15'h0) begin
            failures++;
            $display("FAIL tx_start: got busy=%b crc=%h required busy=1 crc=0", busy, crc);
        end
        strobe(1'b1, 1'b1);
        checks++;
        if (crc !== 15'h4599 || tx_bit_vld !== 1'b1) begin
            failures++;
            $display("FAIL tx_crc: got crc=%h vld=%b required crc=4599 vld=1", crc, tx_bit_vld);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (tx_bit !== seq[14 - i]) begin
                failures++;
                $display("FAIL tx_bit[%0d]: got %b required %b", i, tx_bit, seq[14 - i]);
            end
            strobe(1'($urandom), 1'b0);
            if (i < 14) begin
                checks++;
                if (tx_done !== 1'b0) begin
                    failures++;
                    $display("FAIL tx_done_early[%0d]: got %b required 0", i, tx_done);
                end
            end
        end
        checks++;
        if (tx_done !== 1'b1 || busy !== 1'b0 || tx_bit_vld !== 1'b0) begin
            failures++;
            $display("FAIL tx_done: got done=%b busy=%b vld=%b required 1 0 0",
                     tx_done, busy, tx_bit_vld);
        end
        step();
        checks++;
        if (tx_done !== 1'b0) begin
            failures++;
            $display("FAIL tx_done_pulse: got %b required 0", tx_done);
        end
    endtask

    task automatic test_two_bits();
        pulse_start(1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b1);
        checks++;
        if (crc !== 15'h4EAB || tx_bit_vld !== 1'b1) begin
            failures++;
            $display("FAIL two_bits: got crc=%h vld=%b required crc=4eab vld=1", crc, tx_bit_vld);
        end
        pulse_abort();
    endtask

    // Frame: data bit 1 then the CRC field, optionally with bit 7 flipped; gap idles each strobe.
    task automatic test_rx(input bit flip, input int gap, input string name);
        bit          all[$];
        logic [14:0] c, held;
        int unsigned res;
        bit          exp_ok;
        c = 15'h4599 ^ (flip ? 15'h0080 : 15'h0);
        all.push_back(1'b1);
        for (int i = 14; i >= 0; i--) all.push_back(c[i]);
        res    = poly_rem(all, 15, P15);
        exp_ok = (res == 0);
        pulse_start(1'b1);
        idle_gap(gap);
        strobe(1'b1, 1'b1);
        checks++;
        if (tx_bit_vld !== 1'b0 || busy !== 1'b1 || crc !== 15'h4599) begin
            failures++;
            $display("FAIL %s_enter: got vld=%b busy=%b crc=%h required 0 1 4599",
                     name, tx_bit_vld, busy, crc);
        end
        for (int i = 0; i < 15; i++) begin
            held = crc;
            idle_gap(gap);
            if (gap > 0) begin
                checks++;
                if (crc !== held) begin
                    failures++;
                    $display("FAIL %s_gap_hold[%0d]: got %h required %h", name, i, crc, held);
                end
            end
            strobe(c[14 - i], 1'($urandom));
            if (i < 14) begin
                checks++;
                if (crc_ok !== 1'b0 || crc_err !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_early[%0d]: got ok=%b err=%b required 0 0",
                             name, i, crc_ok, crc_err);
                end
            end
        end
        checks++;
        if (crc_ok !== exp_ok || crc_err !== !exp_ok || busy !== 1'b0 || crc !== 15'(res)) begin
            failures++;
            $display("FAIL %s_result: got ok=%b err=%b busy=%b crc=%h required %b %b 0 %h",
                     name, crc_ok, crc_err, busy, crc, exp_ok, !exp_ok, 15'(res));
        end
        step();
        checks++;
        if (crc_ok !== 1'b0 || crc_err !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse: got ok=%b err=%b required 0 0", name, crc_ok, crc_err);
        end
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        pulse_start(1'b0);
        strobe(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) strobe(1'b0, 1'b0);
        pulse_abort();
        checks++;
        if (busy !== 1'b0 || tx_bit_vld !== 1'b0 || tx_done !== 1'b0 || crc !== 15'h3320) begin
            failures++;
            $display("FAIL abort: got busy=%b vld=%b done=%b crc=%h required 0 0 0 3320",
                     busy, tx_bit_vld, tx_done, crc);
        end
        for (int i = 0; i < 20; i++) begin
            strobe(1'($urandom), 1'($urandom));
            if (tx_done !== 1'b0 || crc !== 15'h3320) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL abort_idle_hold: got change=1 required change=0");
        end
    endtask

    task automatic test_async_reset();
        pulse_start(1'b0);
        strobe(1'b1, 1'b0);
        strobe(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_bit, tx_bit_vld, tx_done, crc_ok, crc_err, busy} !== 6'b0 || crc !== 15'h0) begin
            failures++;
            $display("FAIL async_reset: got outs=%b crc=%h required 000000 0",
                     {tx_bit, tx_bit_vld, tx_done, crc_ok, crc_err, busy}, crc);
        end
        @(negedge clk) rst_n = 1'b1;
        step();
    endtask

    task automatic test_restart_check();
        bit seen = 1'b0;
        pulse_start(1'b1);
        strobe(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0);
        start = 1'b1; mode = 1'b0; din = 1'b1; din_vld = 1'b1;
        step();
        start = 1'b0; din_vld = 1'b0;
        checks++;
        if (crc !== 15'h0 || busy !== 1'b1 || tx_bit_vld !== 1'b0) begin
            failures++;
            $display("FAIL restart: got crc=%h busy=%b vld=%b required 0 1 0", crc, busy, tx_bit_vld);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (crc_ok !== 1'b0 || crc_err !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL restart_no_result: got pulse=1 required pulse=0");
        end
        strobe(1'b1, 1'b1);
        checks++;
        if (crc !== 15'h4599 || tx_bit_vld !== 1'b1) begin
            failures++;
            $display("FAIL restart_mode: got crc=%h vld=%b required 4599 1", crc, tx_bit_vld);
        end
        pulse_abort();
    endtask

    task automatic test_random(input int frames);
        for (int f = 0; f < frames; f++) begin
            bit          msg[$], all[$];
            int          len;
            bit          m, gaps, bad;
            int unsigned r, cw;
            len  = $urandom_range(1, 40);
            m    = 1'($urandom);
            gaps = 1'($urandom);
            bad  = 1'b0;
            for (int i = 0; i < len; i++) msg.push_back(1'($urandom));
            r = poly_rem(msg, 15, P15);
            pulse_start(m);
            for (int i = 0; i < len; i++) begin
                strobe(msg[i], i == len - 1);
                if (gaps) idle_gap($urandom_range(0, 2));
            end
            checks++;
            if (crc !== 15'(r)) begin
                failures++;
                $display("FAIL rand_crc[%0d]: got %h required %h", f, crc, 15'(r));
            end
            if (!m) begin
                for (int i = 14; i >= 0; i--) begin
                    if (tx_bit !== r[i] || tx_bit_vld !== 1'b1) bad = 1'b1;
                    strobe(1'($urandom), 1'($urandom));
                    if (i > 0 && gaps) idle_gap($urandom_range(0, 2));
                end
                checks++;
                if (bad || tx_done !== 1'b1) begin
                    failures++;
                    $display("FAIL rand_tx[%0d]: got bad=%b done=%b required 0 1", f, bad, tx_done);
                end
            end else begin
                cw = r;
                if ($urandom_range(0, 1) == 1) cw = cw ^ (32'd1 << $urandom_range(0, 14));
                all = msg;
                for (int i = 14; i >= 0; i--) all.push_back(cw[i]);
                r = poly_rem(all, 15, P15);
                for (int i = 14; i >= 0; i--) begin
                    strobe(cw[i], 1'($urandom));
                    if (i > 0 && gaps) idle_gap($urandom_range(0, 2));
                end
                checks++;
                if (crc_ok !== (r == 0) || crc_err !== (r != 0) || crc !== 15'(r)) begin
                    failures++;
                    $display("FAIL rand_rx[%0d]: got ok=%b err=%b crc=%h required %b %b %h",
                             f, crc_ok, crc_err, crc, r == 0, r != 0, 15'(r));
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        pulse_start(1'b0);
        strobe(1'b1, 1'b1);
        for (int i = 0; i < 15; i++) strobe(1'b0, 1'b0);
        start = 1'b1; mode = 1'b1; din = 1'b1; din_vld = 1'b1;
        checks++;
        if (tx_done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_tx_done: got %b required 1", tx_done);
        end
        step();
        start = 1'b0; din_vld = 1'b0;
        checks++;
        if (busy !== 1'b1 || crc !== 15'h0 || tx_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart_tx: got busy=%b crc=%h done=%b required 1 0 0",
                     busy, crc, tx_done);
        end
        strobe(1'b1, 1'b1);
        for (int i = 14; i >= 0; i--) strobe(P15[i], 1'b0);
        start = 1'b1; mode = 1'b0;
        checks++;
        if (crc_ok !== 1'b1 || crc_err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_rx_ok: got ok=%b err=%b required 1 0", crc_ok, crc_err);
        end
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || crc !== 15'h0 || crc_ok !== 1'b0 || tx_bit_vld !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart_rx: got busy=%b crc=%h ok=%b vld=%b required 1 0 0 0",
                     busy, crc, crc_ok, tx_bit_vld);
        end
        pulse_abort();
    endtask

    task automatic test_param8();
        bit          msg[$];
        logic [7:0]  data = 8'h31;
        int unsigned r;
        bit          bad = 1'b0;
        for (int i = 7; i >= 0; i--) msg.push_back(data[i]);
        r = poly_rem(msg, 8, P8);
        pulse_start(1'b0);
        for (int i = 0; i < 8; i++) strobe(msg[i], i == 7);
        checks++;
        if (crc8 !== 8'(r) || tx_bit_vld8 !== 1'b1) begin
            failures++;
            $display("FAIL p8_crc: got crc=%h vld=%b required %h 1", crc8, tx_bit_vld8, 8'(r));
        end
        for (int i = 7; i >= 0; i--) begin
            if (tx_bit8 !== r[i]) bad = 1'b1;
            strobe(1'($urandom), 1'b0);
        end
        checks++;
        if (bad || tx_done8 !== 1'b1 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL p8_tx: got bad=%b done=%b busy=%b required 0 1 0", bad, tx_done8, busy8);
        end
        pulse_abort();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0; mode = 1'b0; abort = 1'b0;
        din = 1'b0; din_vld = 1'b0; data_last = 1'b0;
        test_reset();
        test_tx_single();
        test_two_bits();
        test_rx(1'b0, 0, "rx_pass");
        test_rx(1'b1, 0, "rx_fail");
        test_rx(1'b0, 7, "rx_gapped");
        test_abort();
        test_async_reset();
        test_restart_check();
        test_random(24);
        test_back_to_back();
        test_param8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
